// File: rtl/pchinfo_feeder_pkg.sv
// Shared types for the pchinfo batch feeder.
// Supplies fallbacks for NUM_PCH, PCHINFO_BW and LOG2 when define.v is not on the file list.
`ifndef NUM_PCH
`define NUM_PCH 8
`endif
`ifndef PCHINFO_BW
`define PCHINFO_BW 16
`endif
`ifndef LOG2
`define LOG2(x) $clog2(x)
`endif

package pchinfo_feeder_pkg;
  typedef enum logic [1:0] {
    STREAM,
    WAIT_RISE,
    WAIT_FALL
  } feed_state_e;
endpackage

// File: rtl/pchinfo_fifo.sv
// Small skid FIFO with registered occupancy count; DEPTH must be a power of two.
module pchinfo_fifo #(
    parameter int unsigned WIDTH = 17,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers are exactly log2(DEPTH) bits wide, so wrap is free.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];
endmodule

// File: rtl/pchinfo_feeder.sv
// Feeds buffered pchinfo entries to srmem in batches and waits for the wrfull handshake.
// Optional statistics outputs (batch_cnt, stall_cnt) are enabled by PCHINFO_FEEDER_STAT_EN.
module pchinfo_feeder
  import pchinfo_feeder_pkg::*;
#(
  parameter int unsigned NUM_PCH    = `NUM_PCH,
  parameter int unsigned DATA_BW    = `PCHINFO_BW,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [DATA_BW-1:0] in_data,
  input  logic               in_last,
  output logic               in_ready,
  input  logic               wrfull,
  output logic               valid_din,
  output logic [DATA_BW-1:0] din,
  output logic               is_lastdin,
  output logic               req_newdata,
  output logic               batch_done
`ifdef PCHINFO_FEEDER_STAT_EN
  ,
  output logic [15:0]        batch_cnt,
  output logic [15:0]        stall_cnt
`endif
);
  localparam int unsigned BCNT_W = `LOG2(NUM_PCH);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BCNT_W-1:0] BCNT_MAX = BCNT_W'(NUM_PCH - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FIFO_DEPTH);

  feed_state_e       state_q;
  feed_state_e       state_d;
  logic [BCNT_W-1:0] bcnt_q;
  logic [CNT_W-1:0]  fifo_count;
  logic [DATA_BW:0]  fifo_head;
  logic              fifo_push;
  logic              fifo_nonempty;
  logic              head_last;

  assign in_ready      = (fifo_count != CNT_FULL);
  assign fifo_push     = in_valid & in_ready;
  assign fifo_nonempty = (fifo_count != '0);
  assign head_last     = fifo_head[DATA_BW];
  assign din           = fifo_head[DATA_BW-1:0];
  assign req_newdata   = fifo_nonempty | in_valid;

  pchinfo_fifo #(
    .WIDTH (DATA_BW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data ({in_last, in_data}),
    .pop       (valid_din),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  always_comb begin
    state_d    = state_q;
    valid_din  = 1'b0;
    is_lastdin = 1'b0;
    batch_done = 1'b0;
    case (state_q)
      STREAM: begin
        valid_din  = ~wrfull & fifo_nonempty;
        is_lastdin = valid_din & (head_last | (bcnt_q == BCNT_MAX));
        if (is_lastdin) begin
          state_d = WAIT_RISE;
        end
      end
      WAIT_RISE: begin
        if (wrfull) begin
          state_d = WAIT_FALL;
        end
      end
      WAIT_FALL: begin
        if (!wrfull) begin
          state_d    = STREAM;
          batch_done = 1'b1;
        end
      end
      default: state_d = STREAM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= STREAM;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      if (valid_din) begin
        bcnt_q <= is_lastdin ? '0 : bcnt_q + 1'b1;
      end
    end
  end

`ifdef PCHINFO_FEEDER_STAT_EN
  // Stall = entry ready to stream but srmem still busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      batch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (batch_done && batch_cnt != '1) begin
        batch_cnt <= batch_cnt + 1'b1;
      end
      if (state_q == STREAM && fifo_nonempty && wrfull && stall_cnt != '1) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end
`endif
endmodule
